// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: rate defaults, clocks-per-bit math, FSM encoding.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned SYS_RATE_DEF  = 32'd100_000_000;
  localparam int unsigned BAND_RATE_DEF = 32'd921_600;
  localparam int unsigned CNT_W         = 32'd14;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_e;

  function automatic int unsigned cnt_band(input int unsigned sys_rate,
                                           input int unsigned band_rate);
    return sys_rate / band_rate;
  endfunction

  localparam int unsigned CNT_BAND_DEF = cnt_band(SYS_RATE_DEF, BAND_RATE_DEF);

  // Even-parity bit that makes the total number of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line and received-byte outputs of the UART receiver.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;

  modport master (output rx, input rx_data, input rx_valid, input rx_busy,
                  input frame_err, input parity_err);
  modport slave  (input rx, output rx_data, output rx_valid, output rx_busy,
                  output frame_err, output parity_err);
`else
  modport master (output rx, input rx_data, input rx_valid, input rx_busy,
                  input frame_err);
  modport slave  (input rx, output rx_data, output rx_valid, output rx_busy,
                  output frame_err);
`endif
endinterface

// File: rtl/uart_rx_band_gen.sv
// Bit-centre tick generator: first tick half a bit after enable, then every CNT_BAND clocks.
module uart_rx_band_gen
  import uart_pkg::*;
#(
  parameter int unsigned CNT_BAND = CNT_BAND_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CNT_BAND / 32'd2 - 32'd1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CNT_BAND - 32'd1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // down-counter: parked at the half-bit load while disabled
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = HALF_LOAD;
    end else if (cnt_q == {CNT_W{1'b0}}) begin
      cnt_d = FULL_LOAD;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= HALF_LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/8 data LSB first/stop, sampled at bit centres of the synchronized line.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned SYS_RATE  = SYS_RATE_DEF,
  parameter int unsigned BAND_RATE = BAND_RATE_DEF
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.slave bus
);

  localparam int unsigned CNT_BAND = cnt_band(SYS_RATE, BAND_RATE);

  logic       sync1_q, sync2_q, prev_q, rx_s;
  logic [2:0] vld_q;
  logic       fall_s, tick_s, bit_en_s;
  rx_state_e  state_q, state_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d, busy_q, busy_d, frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic       par_bad_q, par_bad_d, parity_err_q, parity_err_d;
`endif

  // synchronizer and edge history; vld_q stops the reset value of 1 faking a falling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      vld_q   <= 3'b000;
    end else begin
      sync1_q <= bus.rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      vld_q   <= {vld_q[1:0], 1'b1};
    end
  end

  assign rx_s     = sync2_q;
  assign fall_s   = vld_q[2] & prev_q & ~rx_s;
  assign bit_en_s = (state_q != ST_IDLE);

  uart_rx_band_gen #(.CNT_BAND(CNT_BAND)) u_band_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (bit_en_s),
    .tick (tick_s)
  );

  // frame FSM next-state and output pulses
  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (fall_s) begin
          state_d   = ST_START;
          bit_idx_d = 3'd0;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) begin
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick_s) begin
          par_bad_d = (rx_s != even_parity(shift_q));
          state_d   = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (tick_s) begin
          state_d     = ST_IDLE;
          frame_err_d = ~rx_s;
`ifdef UART_RX_PARITY_EN
          parity_err_d = par_bad_q;
          rx_valid_d   = rx_s & ~par_bad_q;
`else
          rx_valid_d   = rx_s;
`endif
          rx_data_d = rx_valid_d ? shift_q : rx_data_q;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // frame FSM and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_busy   = busy_q;
  assign bus.frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are modelled bit-by-bit, outcomes queued, a monitor checks pulses.
// Build with UART_RX_PARITY_EN defined to exercise the parity variant.
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int C = CNT_BAND_DEF;
  localparam int H = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  typedef struct {
    logic       valid;
    logic       ferr;
    logic       perr;
    logic [7:0] data;
    int         at;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] last_good = 8'h00;
  exp_t sb_q[$];
  exp_t mon_e;
  logic perr_mon;

  uart_rx_if bus();

  uart_rx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef UART_RX_PARITY_EN
  assign perr_mon = bus.parity_err;
`else
  assign perr_mon = 1'b0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.rx_valid || bus.frame_err || perr_mon) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, bus.rx_valid, bus.frame_err, perr_mon}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("pulse_cycle", cyc, mon_e.at);
        check("rx_valid", {31'd0, bus.rx_valid}, {31'd0, mon_e.valid});
        check("frame_err", {31'd0, bus.frame_err}, {31'd0, mon_e.ferr});
        check("parity_err", {31'd0, perr_mon}, {31'd0, mon_e.perr});
        check("rx_data", {24'd0, bus.rx_data}, {24'd0, mon_e.data});
      end
    end
  end

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_neg(input int target);
    do @(negedge clk); while (cyc < target);
  endtask

  // Drive one frame; the model predicts the outcome and the cycle of the pulse.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic par_flip, input int stop_len);
    logic line_bits [NBITS];
    int   ones;
    logic par;
    logic par_ok;
    int   d0;
    exp_t e;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    par    = logic'(ones % 2) ^ par_flip;
    par_ok = 1'b1;
    line_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) line_bits[i + 1] = d[i];
`ifdef UART_RX_PARITY_EN
    line_bits[9] = par;
    par_ok = ((ones + int'(par)) % 2) == 0;
`endif
    line_bits[NBITS - 1] = stop_bit;
    @(posedge clk);
    #1;
    d0 = cyc;
    e.valid = stop_bit & par_ok;
    e.ferr  = ~stop_bit;
`ifdef UART_RX_PARITY_EN
    e.perr  = ~par_ok;
`else
    e.perr  = 1'b0;
`endif
    if (e.valid) last_good = d;
    e.data = last_good;
    e.at   = d0 + 3 + H + C * (NBITS - 1);
    sb_q.push_back(e);
    for (int i = 0; i < NBITS - 1; i++) begin
      bus.rx = line_bits[i];
      repeat (C) @(posedge clk);
      #1;
    end
    bus.rx = stop_bit;
    repeat (stop_len) @(posedge clk);
    #1;
  endtask

  initial begin
    int d0;
    logic [7:0] b;
    logic sb;
    logic pf;
    bus.rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("reset_rx_data", {24'd0, bus.rx_data}, 32'd0);
    check("reset_busy", {31'd0, bus.rx_busy}, 32'd0);
    check("reset_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("reset_ferr", {31'd0, bus.frame_err}, 32'd0);
    rst = 1'b0;
    idle(20);

    send_frame(8'h55, 1'b1, 1'b0, C - 1);
    idle(30);

    // back-to-back: next start edge half a bit after the stop sample
    send_frame(8'h00, 1'b1, 1'b0, C - 1);
    send_frame(8'hFF, 1'b1, 1'b0, C - 1);
    idle(30);

    // short low glitch: rejected at the start sample
    @(posedge clk);
    #1;
    d0 = cyc;
    bus.rx = 1'b0;
    wait_neg(d0 + 2);
    check("glitch_busy_at_E", {31'd0, bus.rx_busy}, 32'd0);
    wait_neg(d0 + 3);
    check("glitch_busy_after_E", {31'd0, bus.rx_busy}, 32'd1);
    wait_neg(d0 + 40);
    bus.rx = 1'b1;
    wait_neg(d0 + 56);
    check("glitch_busy_at_sample", {31'd0, bus.rx_busy}, 32'd1);
    wait_neg(d0 + 57);
    check("glitch_busy_fell", {31'd0, bus.rx_busy}, 32'd0);
    idle(200);

    // bad stop bit keeps the previous byte
    send_frame(8'hA3, 1'b0, 1'b0, C - 1);
    idle(20);
    check("ferr_keeps_data", {24'd0, bus.rx_data}, {24'd0, last_good});

    // reset in the middle of 0x3C, released while the line is still low
    b = 8'h3C;
    @(posedge clk);
    #1;
    bus.rx = 1'b0;
    repeat (C) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      bus.rx = b[i];
      repeat (C) @(posedge clk);
      #1;
    end
    bus.rx = b[4];
    repeat (H) @(posedge clk);
    #1;
    bus.rx = 1'b0;
    rst = 1'b1;
    last_good = 8'h00;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_busy", {31'd0, bus.rx_busy}, 32'd0);
    check("midrst_rx_data", {24'd0, bus.rx_data}, 32'd0);
    rst = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    check("low_after_rst_busy", {31'd0, bus.rx_busy}, 32'd0);
    idle(20);
    send_frame(8'h81, 1'b1, 1'b0, C - 1);
    idle(30);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, C - 1);
    idle(30);
    send_frame(8'h07, 1'b1, 1'b0, C - 1);
    idle(30);
`endif

    // randomized traffic
    for (int n = 0; n < 22; n++) begin
      b  = 8'($urandom);
      sb = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
      pf = ($urandom_range(0, 4) == 0);
`else
      pf = 1'b0;
`endif
      if (sb && ($urandom_range(0, 1) == 1)) begin
        send_frame(b, sb, pf, $urandom_range(60, C + 40));
      end else begin
        send_frame(b, sb, pf, C - 1);
      end
      if (!sb) begin
        idle(20);
      end else if ($urandom_range(0, 2) == 0) begin
        idle($urandom_range(1, 300));
      end else begin
        bus.rx = 1'b1;
      end
    end

    idle(C * NBITS + 100);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter SYS_RATE, default 100000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAND_RATE, default 921600, meaning serial bit rate in bit/s.
REQ-003 SHALL have derived parameter CNT_BAND = SYS_RATE / BAND_RATE (integer division; 108 at defaults), meaning clocks per bit.
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port rx  input  1  serial line, asynchronous to clk, idle high.
REQ-007 SHALL have port rx_data  output  8  last good received byte.
REQ-008 SHALL have port rx_valid  output  1  one-cycle pulse, rx_data updated.
REQ-009 SHALL have port rx_busy  output  1  high while a frame is being received.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-011 SHALL have port parity_err  output  1  one-cycle pulse, parity mismatch; present only with UART_RX_PARITY_EN.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-013 SHALL use frame format: 1 start (0), 8 data bits LSB first, optional even parity bit, 1 stop (1).
REQ-014 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-015 SHALL define edge cycle E as the first cycle in IDLE where rx_s = 0 and previous rx_s = 1; E moves to START and clears the bit counter.
REQ-016 SHALL sample bit k (start k=0, data k=1..8, parity k=9, stop last) at cycle E + CNT_BAND/2 + k*CNT_BAND.
REQ-017 SHALL return to IDLE with no output pulse when the START sample is 1 (glitch rejection).
REQ-018 SHALL shift data samples into an 8-bit register, LSB first; 3-bit index wraps 7 -> DATA exit.
REQ-019 SHALL, at the STOP sample = 1 with no parity error: load rx_data and pulse rx_valid high for exactly the next cycle.
REQ-020 SHALL, at the STOP sample = 0: pulse frame_err for the next cycle, leave rx_data unchanged, and not assert rx_valid.
REQ-021 SHALL return to IDLE right after the STOP sample (mid-stop), so a start edge from half a bit later is accepted back-to-back.
REQ-022 SHALL hold rx_busy high from E through the STOP sample cycle, low otherwise.
REQ-023 SHALL ignore rx edges outside IDLE; the bit counter width SHALL be 14 bits.

Reset
REQ-024 SHALL, on rst, force: state IDLE, counter 0, synchronizer flops 1, rx_data 0x00, rx_valid 0, rx_busy 0, frame_err 0, parity_err 0.
REQ-025 SHALL abandon a frame in progress when rst asserts mid-frame, with no pulse on any output; after release, a line still low SHALL NOT start a frame until a new 1->0 edge.

Configuration
REQ-026 SHALL, with UART_RX_PARITY_EN defined: receive an even-parity bit after data bit 7; a mismatch pulses parity_err with the STOP outcome and suppresses rx_valid; frame_err is still reported independently.
REQ-027 SHALL, without UART_RX_PARITY_EN: have no parity state, no parity_err port, and a frame 1 bit shorter.

Structure
REQ-028 SHALL place SYS_RATE/BAND_RATE defaults, the CNT_BAND computation and the state encoding constants in the shared package uart_pkg.
REQ-029 SHALL split out one sub-module, uart_rx_band_gen: a bit-tick generator that, when enabled, pulses at half-bit then every CNT_BAND cycles, and reloads on disable.

Verification
REQ-030 SHALL cover: frame 0x55 at defaults -> rx_data=0x55, rx_valid one cycle, exactly E+54+9*108+1.
REQ-031 SHALL cover: back-to-back 0x00 then 0xFF, start edge half a bit after first stop sample -> two rx_valid pulses, data 0x00 then 0xFF.
REQ-032 SHALL cover: rx low for 40 cycles then high -> no rx_valid, no frame_err, rx_busy falls at E+54.
REQ-033 SHALL cover: 0xA3 with stop bit held 0 -> frame_err pulse, rx_valid 0, rx_data keeps previous value.
REQ-034 SHALL cover: rst asserted at bit 4 of 0x3C, then 0x81 sent -> no pulse for 0x3C, rx_data=0x81.
REQ-035 SHALL cover (UART_RX_PARITY_EN): 0x07 with parity 0 -> parity_err pulse, rx_valid 0; with parity 1 -> rx_valid, rx_data=0x07.
